// File: rtl/bias_add_stream.sv
// bias_add_stream: adds the selected layer's bias vector to a streamed accumulator vector, saturating each sum.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, layer_sel         one-cycle start pulse and layer index (latched on start)
//   busy, done               busy from accepted start until done; done pulses once per vector
//   rom_addr, rom_data       bias ROM address out, read data in (1-cycle latency)
//   in_valid/in_ready/in_data        accumulator beat stream in
//   out_valid/out_ready/out_data/out_last  saturated sum stream out; out_last marks beat DEPTH-1
// Optional: define BIAS_RELU_EN to clamp negative results to 0 after saturation.
`ifndef BIT_LENGTH
`define BIT_LENGTH 16
`endif
module bias_add_stream #(
    parameter int DEPTH  = 24,
    parameter int LAYERS = 3,
    parameter int ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             layer_sel,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [`BIT_LENGTH-1:0] rom_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`BIT_LENGTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`BIT_LENGTH-1:0] out_data,
    output logic                   out_last
);
    localparam int W = `BIT_LENGTH;
    localparam int IW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;
    state_t state, state_nx;
    logic [1:0] layer;
    logic [IW-1:0] idx;
    logic accept;
    logic [ADDR_W-1:0] base;
    logic [W:0] sum;
    logic [W-1:0] sat, res;
    assign base = ADDR_W'(layer) * ADDR_W'(DEPTH);
    assign busy = state != IDLE;
    assign in_ready = state == STREAM && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    // Look one address ahead on accept so the next bias lands with the next beat;
    // the final accept stays on the layer's last word instead of touching the next layer.
    assign rom_addr = state == PRIME  ? base :
                      state == STREAM ? base + ADDR_W'(idx) + ADDR_W'(accept && idx != LAST) :
                      state == DRAIN  ? base + ADDR_W'(LAST) : '0;
    assign sum = {in_data[W-1], in_data} + {rom_data[W-1], rom_data};
    // Overflow when the two top bits of the widened sum disagree; the sign bit picks the rail.
    assign sat = sum[W] != sum[W-1] ? {sum[W], {(W-1){!sum[W]}}} : sum[W-1:0];
`ifdef BIAS_RELU_EN
    assign res = sat[W-1] ? '0 : sat;
`else
    assign res = sat;
`endif
    // A start arriving while done is high is the done cycle and is dropped.
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE   ? (start && !done && 32'(layer_sel) < LAYERS ? PRIME : IDLE) :
                   state == PRIME  ? STREAM :
                   state == STREAM ? (accept && idx == LAST ? DRAIN : STREAM) :
                                     (out_valid && out_ready ? IDLE : DRAIN);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            layer     <= '0;
            idx       <= '0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state == DRAIN && out_valid && out_ready;
            if (state == IDLE && state_nx == PRIME) begin
                layer <= layer_sel;
                idx   <= '0;
            end
            if (accept) begin
                out_data  <= res;
                out_valid <= 1'b1;
                out_last  <= idx == LAST;
                idx       <= idx + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bias_add_stream.sv
// tb_bias_add_stream: scoreboard bench for bias_add_stream with a behavioural bias ROM and saturating-add model.
`ifndef BIT_LENGTH
`define BIT_LENGTH 16
`endif
module tb_bias_add_stream;
    localparam int W = `BIT_LENGTH;
    localparam int DEPTH = 24;
    localparam int LAYERS = 3;
    localparam int ADDR_W = 16;
    localparam int NROM = DEPTH * LAYERS;
    logic clk = 0, rst = 1, start = 0;
    logic [1:0] layer_sel = 0;
    logic busy, done, in_ready, out_valid, out_last;
    logic [ADDR_W-1:0] rom_addr;
    logic [W-1:0] rom_data, out_data;
    logic [W-1:0] in_data = 0;
    logic in_valid = 0, out_ready = 1;
    logic [W-1:0] rom [NROM];
    typedef struct {logic [W-1:0] d; logic l;} beat_t;
    beat_t sb[$];
    int ntest = 0, nfail = 0, orm = 0;
    bit mon_en = 0, pend_done = 0, prev_hold = 0;
    logic [W-1:0] prev_data;

    bias_add_stream #(.DEPTH(DEPTH), .LAYERS(LAYERS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_addr < NROM ? rom[rom_addr] : '0;

    function automatic logic [W-1:0] model(logic [W-1:0] a, logic [W-1:0] b);
        longint mx = (longint'(1) << (W - 1)) - 1;
        longint s = longint'($signed(a)) + longint'($signed(b));
        if (s > mx) s = mx;
        if (s < -mx - 1) s = -mx - 1;
`ifdef BIAS_RELU_EN
        if (s < 0) s = 0;
`endif
        return W'(s);
    endfunction

    task automatic chk(string n, longint a, longint e);
        ntest++;
        if (a != e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = orm == 0 ? 1'b1 : orm == 1 ? !out_ready : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) if (mon_en) begin
        beat_t b;
        if (pend_done) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
        end else if (done) chk("done_spurious", done, 0);
        pend_done = 0;
        if (prev_hold) chk("hold_stable", {out_valid, out_data}, {1'b1, prev_data});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                ntest++;
                nfail++;
                $display("FAIL extra_beat: got data %0h with no beat expected", out_data);
            end else begin
                b = sb.pop_front();
                chk("out_data", out_data, b.d);
                chk("out_last", out_last, b.l);
                pend_done = out_last;
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
    end

    // om: out_ready mode (0 always, 1 toggle, 2 random); gm: gap mode (0 none, 1 two-idle, 2 random);
    // dm: data mode (0 const 100, 1 random, 2 saturation pair then random).
    task automatic run_vec(input int l, input int om, input int gm, input int dm, input int stop_at,
                           input bit pulse, input bit dstart);
        int base = l * DEPTH;
        int t, w;
        logic [W-1:0] x;
        orm = om;
        @(posedge clk);
        #1;
        start = 1;
        layer_sel = 2'(l);
        @(posedge clk);
        #1;
        start = 0;
        @(negedge clk);
        chk("prime_busy", busy, 1);
        chk("prime_addr", rom_addr, base);
        for (int k = 0; k < stop_at; k++) begin
            t = gm == 0 ? 0 : gm == 1 ? 2 : int'($urandom_range(0, 2));
            repeat (t) @(negedge clk);
            x = dm == 0 ? W'(100) : dm == 2 && k == 0 ? W'('h0100) : dm == 2 && k == 1 ? W'('hFF00) : W'($urandom);
            if (pulse && k == 5) begin
                start = 1;
                layer_sel = 2'((l + 1) % LAYERS);
            end
            in_valid = 1;
            in_data = x;
            #1;
            for (w = 0; w < 200 && !in_ready; w++) begin
                chk("stall_addr", rom_addr, base + k);
                @(negedge clk);
                #1;
                start = 0;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", in_ready, 1);
                in_valid = 0;
                return;
            end
            chk("in_addr", rom_addr, base + k + (k < DEPTH - 1 ? 1 : 0));
            sb.push_back('{model(x, rom[base + k]), k == DEPTH - 1});
            @(negedge clk);
            in_valid = 0;
            start = 0;
        end
        if (stop_at < DEPTH) return;
        for (w = 0; w < 200 && !done; w++) @(negedge clk);
        chk("done_seen", done, 1);
        chk("sb_empty", sb.size(), 0);
        if (dstart) begin
            start = 1;
            layer_sel = 0;
            @(negedge clk);
            start = 0;
            chk("done_start_ignored", busy, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < NROM; i++) rom[i] = W'((i % DEPTH) + 1);
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 0;
        mon_en = 1;
        run_vec(1, 0, 0, 0, DEPTH, 0, 0);
        run_vec(1, 1, 0, 0, DEPTH, 0, 0);
        run_vec(1, 0, 1, 0, DEPTH, 0, 1);
        rom[0] = W'('h7FF0);
        rom[1] = W'('h8010);
        run_vec(0, 2, 0, 2, DEPTH, 0, 0);
        @(negedge clk);
        start = 1;
        layer_sel = 3;
        @(negedge clk);
        start = 0;
        repeat (3) begin
            @(negedge clk);
            chk("bad_layer_busy", busy, 0);
            chk("bad_layer_addr", rom_addr, 0);
            chk("bad_layer_in_ready", in_ready, 0);
        end
        run_vec(2, 1, 2, 1, DEPTH, 1, 0);
        run_vec(0, 0, 0, 1, 10, 0, 0);
        for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
        chk("pre_reset_drain", sb.size(), 0);
        rst = 1;
        @(negedge clk);
        chk_reset();
        rst = 0;
        sb.delete();
        pend_done = 0;
        prev_hold = 0;
        repeat (3) @(negedge clk);
        run_vec(2, 0, 0, 1, DEPTH, 0, 0);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NROM; i++) rom[i] = W'($urandom);
            run_vec(int'($urandom_range(0, LAYERS - 1)), 2, 2, 1, DEPTH,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
